// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register file.
// The slave side is the arbiter; the master side is the requester/regfile environment.
interface regfile_wr_arbiter_if #(
    parameter int width = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [5*NREQ-1:0]     req_addr;
    logic [width*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rf_we;
    logic [4:0]            rf_addr;
    logic [width-1:0]      rf_wdata;
    logic [IDW-1:0]        rf_src;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_addr, rf_wdata, rf_src
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_addr, rf_wdata, rf_src
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port, one registered stage.
// Optional REGWR_ARB_PERF_EN adds saturating grant/drop counters.
module regfile_wr_arbiter #(
    parameter int width = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    regfile_wr_arbiter_if.slave bus
`ifdef REGWR_ARB_PERF_EN
    ,
    output logic [16*NREQ-1:0]  perf_grants,
    output logic [15:0]         perf_drops
`endif
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   gidx;
    logic [NREQ-1:0]  grant;
    logic             xfer;
    logic [4:0]       gaddr;
    logic [width-1:0] gdata;
    logic             stage_valid;
    logic [4:0]       addr_q;
    logic [width-1:0] data_q;
    logic [IDW-1:0]   src_q;

    // Two passes: requesters at/after the pointer first, then the wrapped ones.
    always_comb begin
        grant = '0;
        gidx  = '0;
        xfer  = 1'b0;
        gaddr = '0;
        gdata = '0;
        if (rst_n && !hold) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!xfer && bus.req_valid[i] && IDW'(i) >= rr_ptr) begin
                    xfer     = 1'b1;
                    grant[i] = 1'b1;
                    gidx     = IDW'(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!xfer && bus.req_valid[i] && IDW'(i) < rr_ptr) begin
                    xfer     = 1'b1;
                    grant[i] = 1'b1;
                    gidx     = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gaddr = bus.req_addr[5*i +: 5];
                gdata = bus.req_data[width*i +: width];
            end
        end
    end

    assign ptr_next = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            src_q       <= '0;
            rr_ptr      <= '0;
        end else if (!hold) begin
            if (xfer) begin
                rr_ptr <= ptr_next;
                if (gaddr != 5'd0) begin
                    stage_valid <= 1'b1;
                    addr_q      <= gaddr;
                    data_q      <= gdata;
                    src_q       <= gidx;
                end else begin
                    stage_valid <= 1'b0;
                end
            end else begin
                stage_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rf_we     = stage_valid & ~hold;
    assign bus.rf_addr   = addr_q;
    assign bus.rf_wdata  = data_q;
    assign bus.rf_src    = src_q;

`ifdef REGWR_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_drops  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && perf_grants[16*i +: 16] != 16'hFFFF)
                    perf_grants[16*i +: 16] <= perf_grants[16*i +: 16] + 16'd1;
            end
            if (xfer && gaddr == 5'd0 && perf_drops != 16'hFFFF)
                perf_drops <= perf_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter (NREQ=3, width=32).
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic hold;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_wr_arbiter_if #(.width(32), .NREQ(3), .IDW(2)) bus ();

`ifdef REGWR_ARB_PERF_EN
    logic [47:0] perf_grants;
    logic [15:0] perf_drops;
`endif

    regfile_wr_arbiter #(.width(32), .NREQ(3), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .bus   (bus)
`ifdef REGWR_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_drops  (perf_drops)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  ready;
        logic        we;
        logic        chk;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_src;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(logic h, logic [2:0] v, logic [14:0] a,
                                 logic [95:0] d, logic [2:0] rdy, logic we,
                                 logic c, logic [4:0] ea, logic [31:0] ed,
                                 logic [1:0] es);
        vec_t r;
        r.hold = h; r.valid = v; r.addr = a; r.data = d;
        r.ready = rdy; r.we = we; r.chk = c;
        r.e_addr = ea; r.e_data = ed; r.e_src = es;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [14:0] a_all, a_one, a_zero, a_hold;
    logic [95:0] d_all, d_one, d_zero, d_hold;

    initial begin
        a_all  = {5'd3, 5'd2, 5'd1};
        d_all  = {32'd30, 32'd20, 32'd10};
        a_one  = {5'd0, 5'd5, 5'd0};
        d_one  = {32'd0, 32'hDEADBEEF, 32'd0};
        a_zero = {5'd0, 5'd0, 5'd4};
        d_zero = {32'd77, 32'd0, 32'd9};
        a_hold = {5'd0, 5'd6, 5'd8};
        d_hold = {32'd0, 32'd66, 32'd55};

        // idle after reset
        for (int i = 0; i < 5; i++)
            vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 0, 1, 5'd0, 32'd0, 2'd0));
        // all three valid: rotation 0,1,2,0,1,2
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b001, 0, 1, 5'd0, 32'd0, 2'd0));
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b010, 1, 1, 5'd1, 32'd10, 2'd0));
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b100, 1, 1, 5'd2, 32'd20, 2'd1));
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b001, 1, 1, 5'd3, 32'd30, 2'd2));
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b010, 1, 1, 5'd1, 32'd10, 2'd0));
        vecs.push_back(row(0, 3'b111, a_all, d_all, 3'b100, 1, 1, 5'd2, 32'd20, 2'd1));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 1, 1, 5'd3, 32'd30, 2'd2));
        // single request from requester 1
        vecs.push_back(row(0, 3'b010, a_one, d_one, 3'b010, 0, 0, 5'd0, 32'd0, 2'd0));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 1, 1, 5'd5, 32'hDEADBEEF, 2'd1));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 0, 0, 5'd0, 32'd0, 2'd0));
        // rr_ptr=2: addr-0 drop from requester 2, then requester 0
        vecs.push_back(row(0, 3'b101, a_zero, d_zero, 3'b100, 0, 0, 5'd0, 32'd0, 2'd0));
        vecs.push_back(row(0, 3'b001, a_zero, d_zero, 3'b001, 0, 0, 5'd0, 32'd0, 2'd0));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 1, 1, 5'd4, 32'd9, 2'd0));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 0, 0, 5'd0, 32'd0, 2'd0));
        // accept requester 0, then hold 3 cycles with requester 1 waiting
        vecs.push_back(row(0, 3'b001, a_hold, d_hold, 3'b001, 0, 0, 5'd0, 32'd0, 2'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(row(1, 3'b010, a_hold, d_hold, 3'b000, 0, 1, 5'd8, 32'd55, 2'd0));
        vecs.push_back(row(0, 3'b010, a_hold, d_hold, 3'b010, 1, 1, 5'd8, 32'd55, 2'd0));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 1, 1, 5'd6, 32'd66, 2'd1));
        vecs.push_back(row(0, 3'b000, '0, '0, 3'b000, 0, 0, 5'd0, 32'd0, 2'd0));

        rst_n = 1'b0;
        hold = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr = a_all;
        bus.req_data = d_all;
        @(negedge clk);
        #1 check("ready_in_reset", 64'(bus.req_ready), 64'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            hold = vecs[i].hold;
            bus.req_valid = vecs[i].valid;
            bus.req_addr = vecs[i].addr;
            bus.req_data = vecs[i].data;
            #1;
            check($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].ready));
            check($sformatf("v%0d_we", i), 64'(bus.rf_we), 64'(vecs[i].we));
            if (vecs[i].chk) begin
                check($sformatf("v%0d_addr", i), 64'(bus.rf_addr), 64'(vecs[i].e_addr));
                check($sformatf("v%0d_data", i), 64'(bus.rf_wdata), 64'(vecs[i].e_data));
                check($sformatf("v%0d_src", i), 64'(bus.rf_src), 64'(vecs[i].e_src));
            end
        end

`ifdef REGWR_ARB_PERF_EN
        check("perf_grants", 64'(perf_grants), 64'({16'd3, 16'd4, 16'd4}));
        check("perf_drops", 64'(perf_drops), 64'd1);
`endif

        // reset while a write is staged; rr_ptr was left at 2
        @(negedge clk);
        bus.req_valid = 3'b001;
        bus.req_addr = {5'd0, 5'd7, 5'd9};
        bus.req_data = {32'd0, 32'h77, 32'h99};
        #1 check("rst_pre_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_staged_we", 64'(bus.rf_we), 64'd1);
        check("rst_ready_low", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 3'b011;
        #1 check("rst_we_lost", 64'(bus.rf_we), 64'd0);
        check("rst_ptr_zero", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        bus.req_valid = 3'b000;
        #1 check("post_rst_we", 64'(bus.rf_we), 64'd1);
        check("post_rst_addr", 64'(bus.rf_addr), 64'd9);
        check("post_rst_data", 64'(bus.rf_wdata), 64'h99);
        check("post_rst_src", 64'(bus.rf_src), 64'd0);

`ifdef REGWR_ARB_PERF_EN
        check("perf_grants_rst", 64'(perf_grants), 64'({16'd0, 16'd0, 16'd1}));
        check("perf_drops_rst", 64'(perf_drops), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
